// File: rtl/div_unit.sv
// Multicycle signed restoring divider (quotient -> lo, remainder -> hi), one quotient bit per clock.
// Optional build macro DIV_UNSIGNED_EN adds an is_unsigned input for DIVU semantics.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
`ifdef DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} stateType;

    stateType         stateReg;
    logic [CNT_W-1:0] cntReg;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quotReg;
    logic [WIDTH-1:0] dvsrReg;
    logic             negQuotReg;
    logic             negRemReg;

    logic             signedOp;
    logic             dividendNeg;
    logic             divisorNeg;
    logic [WIDTH-1:0] dividendMag;
    logic [WIDTH-1:0] divisorMag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        signedOp = 1'b1;
`ifdef DIV_UNSIGNED_EN
        signedOp = !is_unsigned;
`endif
        dividendNeg = signedOp & dividend[WIDTH-1];
        divisorNeg  = signedOp & divisor[WIDTH-1];
        // The most negative value maps onto itself, which is the correct unsigned magnitude.
        dividendMag = dividendNeg ? -dividend : dividend;
        divisorMag  = divisorNeg  ? -divisor  : divisor;
        shifted     = {remReg, quotReg[WIDTH-1]};
        trial       = shifted - {1'b0, dvsrReg};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg   <= IDLE;
            cntReg     <= '0;
            remReg     <= '0;
            quotReg    <= '0;
            dvsrReg    <= '0;
            negQuotReg <= 1'b0;
            negRemReg  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Zero divisor completes at once and leaves hi/lo untouched.
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            dvsrReg    <= divisorMag;
                            quotReg    <= dividendMag;
                            remReg     <= '0;
                            negQuotReg <= dividendNeg ^ divisorNeg;
                            negRemReg  <= dividendNeg;
                            cntReg     <= '0;
                            busy       <= 1'b1;
                            stateReg   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (trial[WIDTH]) begin
                        remReg  <= shifted[WIDTH-1:0];
                        quotReg <= {quotReg[WIDTH-2:0], 1'b0};
                    end else begin
                        remReg  <= trial[WIDTH-1:0];
                        quotReg <= {quotReg[WIDTH-2:0], 1'b1};
                    end
                    cntReg <= cntReg + CNT_W'(1);
                    if (cntReg == CNT_W'(WIDTH - 1)) begin
                        stateReg <= FIN;
                    end
                end
                FIN: begin
                    lo       <= negQuotReg ? -quotReg : quotReg;
                    hi       <= negRemReg  ? -remReg  : remReg;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    stateReg <= IDLE;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed MIPS DIV cases plus randomized operands
// checked against a 64-bit arithmetic reference model.
module tb_div_unit;

    localparam int WIDTH = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              isUnsigned = 1'b0;
    logic [WIDTH-1:0]  dividend = '0;
    logic [WIDTH-1:0]  divisor = '0;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    int errCount   = 0;
    int checkCount = 0;
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;

    div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
`ifdef DIV_UNSIGNED_EN
        .is_unsigned(isUnsigned),
`endif
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: widen to 64 bits so the -2^31 / -1 case is exact, then keep the low word.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic u,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (u) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        lq = sa / sb;
        lr = sa % sb;
        q = lq[31:0];
        r = lr[31:0];
    endfunction

    // Called and returns at #1 after a rising edge.
    task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input logic u,
                          input int injectAt, input int watch);
        logic [31:0] q, r;
        int cycles, extraDone;
        if (b != 0) begin
            model(a, b, u, q, r);
            expLo = q;
            expHi = r;
        end
        dividend   = a;
        divisor    = b;
        isUnsigned = u;
        start      = 1'b1;
        @(posedge clock); #1;
        start  = 1'b0;
        cycles = 0;
        checkVal("busy_start", 32'(busy), 32'(b != 0));
        while (!done && cycles < WIDTH + 20) begin
            @(posedge clock); #1;
            cycles++;
            if (cycles == injectAt) begin
                start    = 1'b1;
                dividend = ~a;
                divisor  = b + 32'd3;
            end else begin
                start = 1'b0;
            end
            if (cycles == 10 && b != 0) checkVal("busy_mid", 32'(busy), 32'd1);
        end
        start = 1'b0;
        checkVal("latency", 32'(cycles), (b == 0) ? 32'd0 : 32'(WIDTH + 1));
        checkVal("div_zero", 32'(div_zero), 32'(b == 0));
        checkVal("lo", lo, expLo);
        checkVal("hi", hi, expHi);
        @(posedge clock); #1;
        checkVal("done_one_cycle", 32'(done), 32'd0);
        checkVal("dz_one_cycle", 32'(div_zero), 32'd0);
        if (watch > 0) begin
            extraDone = 0;
            repeat (watch) begin
                @(posedge clock); #1;
                if (done) extraDone++;
            end
            checkVal("no_extra_done", 32'(extraDone), 32'd0);
        end
        $display("div a=%h b=%h u=%0d -> lo=%h hi=%h dz=%0d lat=%0d", a, b, u, lo, hi, (b == 0), cycles);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int kind, doneSeen;
        logic u;

        repeat (3) @(posedge clock);
        #1;
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_done", 32'(done), 32'd0);
        checkVal("rst_dz", 32'(div_zero), 32'd0);
        checkVal("rst_hi", hi, 32'd0);
        checkVal("rst_lo", lo, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        runDiv(32'd100, 32'd7, 1'b0, 0, 0);
        runDiv(32'hFFFFFF9C, 32'd7, 1'b0, 0, 0);
        runDiv(32'd100, 32'hFFFFFFF9, 1'b0, 0, 0);
        runDiv(32'd5, 32'd0, 1'b0, 0, 5);
        runDiv(32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0);
        runDiv(32'd1000, 32'd9, 1'b0, 10, 40);

        // Reset asserted mid-division, away from a clock edge.
        runDiv(32'd100, 32'd7, 1'b0, 0, 0);
        dividend = 32'd12345;
        divisor  = 32'd17;
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checkVal("midrst_busy", 32'(busy), 32'd0);
        checkVal("midrst_done", 32'(done), 32'd0);
        checkVal("midrst_hi", hi, 32'd0);
        checkVal("midrst_lo", lo, 32'd0);
        expHi = '0;
        expLo = '0;
        @(negedge clock);
        reset = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) doneSeen++;
        end
        checkVal("midrst_no_done", 32'(doneSeen), 32'd0);
        runDiv(32'd12345, 32'd17, 1'b0, 0, 0);

`ifdef DIV_UNSIGNED_EN
        runDiv(32'hFFFFFFFF, 32'd2, 1'b1, 0, 0);
        runDiv(32'hFFFFFFFF, 32'd2, 1'b0, 0, 0);
`endif

        for (int i = 0; i < 30; i++) begin
            kind = int'($urandom_range(0, 5));
            a = $urandom;
            b = $urandom;
            case (kind)
                1: begin
                    a = 32'($signed($urandom_range(0, 400)) - 200);
                    b = 32'($signed($urandom_range(0, 400)) - 200);
                end
                2: b = 32'd0;
                3: begin
                    a = 32'h80000000;
                    b = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'($urandom_range(1, 50));
                end
                4: b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20)) : -32'($urandom_range(1, 20));
                default: ;
            endcase
            u = 1'b0;
`ifdef DIV_UNSIGNED_EN
            u = 1'($urandom_range(0, 1));
`endif
            runDiv(a, b, u, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
